// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 32-bit VRAM between CPU byte writes
// (buffered in a small FIFO) and fixed-latency video fetch reads.
// Video fetch always wins; queued writes drain in slots with no fetch.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_LAT    = 1
) (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic        cpu_full,
  output logic        wr_overflow,
  input  logic        ovf_clr,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [31:0] vid_q,
  output logic        vid_valid,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [12:0] word;
    logic [1:0]  lane;
    logic [7:0]  data;
  } wr_req_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  wr_req_t         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  wr_req_t         head;
  wr_req_t         new_req;
  logic            vram_wr, empty, push, pop, drop;
  state_t          state_q, state_d;
  logic [RAM_LAT:1] vld_pipe;

  // Fullness uses occupancy at the start of the cycle; a same-cycle pop
  // never makes room for the incoming write.
  assign vram_wr  = cpu_we & cpu_addr[15];
  assign cpu_full = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = vram_wr & ~cpu_full;
  assign drop     = vram_wr & cpu_full;
  assign head     = fifo_mem[rd_ptr];
  assign new_req  = '{word: cpu_addr[12:0], lane: cpu_addr[14:13], data: cpu_din};

  // FIFO storage: data only, validity is tracked by the pointers.
  always_ff @(posedge clk_ram) begin
    if (push) fifo_mem[wr_ptr] <= new_req;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset)        wr_overflow <= 1'b0;
    else if (drop)    wr_overflow <= 1'b1;
    else if (ovf_clr) wr_overflow <= 1'b0;
  end

  // Issue decision: fetch first, otherwise pop one queued write.
  always_comb begin
    state_d = IDLE;
    pop     = 1'b0;
    if (vid_req) begin
      state_d = READ;
    end else if (!empty) begin
      state_d = WRITE;
      pop     = 1'b1;
    end
  end

  // Issue state register.
  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered RAM port; address holds its last value in idle cycles.
  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_be    <= '0;
      ram_wdata <= '0;
    end else begin
      case (state_d)
        READ: begin
          ram_addr <= vid_addr;
          ram_we   <= 1'b0;
          ram_be   <= '0;
        end
        WRITE: begin
          ram_addr  <= head.word;
          ram_we    <= 1'b1;
          ram_be    <= 4'b0001 << head.lane;
          ram_wdata <= {4{head.data}};
        end
        default: begin
          ram_we <= 1'b0;
          ram_be <= '0;
        end
      endcase
    end
  end

  // Read-latency tracker: bit k is set k cycles after a read sits on the port.
  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= (state_q == READ);
      for (int k = 2; k <= RAM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Capture returning RAM data into the video output register.
  always_ff @(posedge clk_ram or posedge reset) begin
    if (reset) begin
      vid_valid <= 1'b0;
      vid_q     <= '0;
    end else begin
      vid_valid <= vld_pipe[RAM_LAT];
      if (vld_pipe[RAM_LAT]) vid_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a 1-cycle-latency RAM model.
module tb_vram_arbiter;

  logic        clk_ram = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_full;
  logic        wr_overflow;
  logic        ovf_clr;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [31:0] vid_q;
  logic        vid_valid;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  vram_arbiter #(.FIFO_DEPTH(4), .RAM_LAT(1)) dut (
    .clk_ram(clk_ram), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_full(cpu_full), .wr_overflow(wr_overflow), .ovf_clr(ovf_clr),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_q(vid_q), .vid_valid(vid_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk_ram = ~clk_ram;

  typedef struct {
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } wr_t;
  typedef struct {
    logic [31:0] d;
    int          due;
  } rd_t;

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int  n_cmp = 0, n_err = 0;
  int  cyc = 0;
  int  wr_seen = 0, rd_seen = 0;
  logic [31:0] mem [8192];

  function automatic logic [31:0] finit(input logic [12:0] a);
    logic [15:0] x;
    x = {3'b000, a};
    return {16'hC0DE ^ x, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Single-port RAM model: read-before-write, one cycle latency.
  always @(posedge clk_ram) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  always @(posedge clk_ram) cyc <= cyc + 1;

  // Output monitor / scoreboard.
  always @(negedge clk_ram) begin : mon
    wr_t w;
    rd_t r;
    if (!reset) begin
      if (ram_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) chk("wr_spurious", ram_we, 1'b0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", ram_addr, w.addr);
          chk("wr_be", ram_be, w.be);
          chk("wr_data", ram_wdata, w.wd);
        end
      end
      if (vid_valid) begin
        rd_seen++;
        if (exp_rd.size() == 0) chk("rd_spurious", vid_valid, 1'b0);
        else begin
          r = exp_rd.pop_front();
          chk("rd_data", vid_q, r.d);
          chk("rd_cycle", cyc, r.due);
        end
      end
      if (exp_rd.size() > 0 && exp_rd[0].due < cyc) begin
        chk("rd_late", cyc, exp_rd[0].due);
        void'(exp_rd.pop_front());
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a[12:0];
    w.be   = 4'b0001 << a[14:13];
    w.wd   = {4{d}};
    exp_wr.push_back(w);
  endtask

  // Drive one cycle of stimulus, then return 1ns after the closing edge.
  task automatic step(input logic vr, input logic [12:0] va, input logic [31:0] rexp,
                      input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic clr);
    rd_t r;
    vid_req = vr; vid_addr = va; cpu_we = we; cpu_addr = a; cpu_din = d; ovf_clr = clr;
    if (vr) begin
      r.d = rexp; r.due = cyc + 3;
      exp_rd.push_back(r);
    end
    @(posedge clk_ram); #1;
    vid_req = 1'b0; cpu_we = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 13'h0, 32'h0, 1'b0, 16'h0, 8'h0, 1'b0);
  endtask

  task automatic nchk();
    @(negedge clk_ram); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vid_q"}, vid_q, 32'h0);
    chk({tag, "_vid_valid"}, vid_valid, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, 13'h0);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
    chk({tag, "_ram_be"}, ram_be, 4'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_cpu_full"}, cpu_full, 1'b0);
    chk({tag, "_ovf"}, wr_overflow, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int ws, rs;
    logic [31:0] merged;
    logic [15:0] a16;
    for (int i = 0; i < 8192; i++) mem[i] = finit(13'(i));
    mem[13'h1ABC] = 32'hDEADBEEF;
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; ovf_clr = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (3) @(posedge clk_ram);
    nchk();
    chk_zero("rst");
    @(posedge clk_ram); #1;
    reset = 1'b0;
    idle(2);

    // Single CPU write reaches the port two clocks after the strobe.
    push_wr(16'hA005, 8'h3C);
    step(1'b0, 13'h0, 32'h0, 1'b1, 16'hA005, 8'h3C, 1'b0);
    nchk();
    chk("t1_we_n1", ram_we, 1'b0);
    chk("t1_full", cpu_full, 1'b0);
    nchk();
    chk("t1_we_n2", ram_we, 1'b1);
    chk("t1_addr", ram_addr, 13'h0005);
    chk("t1_be", ram_be, 4'b0010);
    chk("t1_wdata", ram_wdata, 32'h3C3C3C3C);
    idle(3);

    // Single video fetch.
    step(1'b1, 13'h1ABC, 32'hDEADBEEF, 1'b0, 16'h0, 8'h0, 1'b0);
    nchk();
    chk("t2_addr", ram_addr, 13'h1ABC);
    chk("t2_we", ram_we, 1'b0);
    idle(5);

    // Three writes queued under a 10-cycle fetch burst.
    ws = wr_seen; rs = rd_seen;
    for (int i = 0; i < 10; i++) begin
      a16 = {1'b1, 2'(i), 13'(13'h40 + i)};
      if (i < 3) push_wr(a16, 8'(8'hA0 + i));
      step(1'b1, 13'(13'h100 + i), finit(13'(13'h100 + i)), i < 3, a16, 8'(8'hA0 + i), 1'b0);
    end
    nchk();
    chk("t3_no_wr_burst", wr_seen - ws, 0);
    for (int k = 0; k < 3; k++) begin
      nchk();
      chk("t3_wr_after", ram_we, 1'b1);
    end
    idle(4);
    chk("t3_rd_count", rd_seen - rs, 10);

    // Overflow: five writes while fetch holds the port.
    ws = wr_seen;
    for (int i = 0; i < 5; i++) begin
      a16 = {1'b1, 2'(i), 13'(13'h60 + i)};
      if (i == 3) chk("t4_not_full", cpu_full, 1'b0);
      if (i == 4) chk("t4_full", cpu_full, 1'b1);
      if (i < 4) push_wr(a16, 8'(8'hB0 + i));
      step(1'b1, 13'(13'h180 + i), finit(13'(13'h180 + i)), 1'b1, a16, 8'(8'hB0 + i), 1'b0);
    end
    chk("t4_ovf_set", wr_overflow, 1'b1);
    step(1'b1, 13'h185, finit(13'h185), 1'b1, 16'h8025, 8'hEE, 1'b1);
    chk("t4_set_wins", wr_overflow, 1'b1);
    step(1'b1, 13'h186, finit(13'h186), 1'b0, 16'h0, 8'h0, 1'b1);
    chk("t4_ovf_clr", wr_overflow, 1'b0);
    idle(8);
    chk("t4_wr_count", wr_seen - ws, 4);
    chk("t4_full_drained", cpu_full, 1'b0);

    // Writes outside VRAM are ignored.
    ws = wr_seen;
    step(1'b0, 13'h0, 32'h0, 1'b1, 16'h4000, 8'h77, 1'b0);
    step(1'b0, 13'h0, 32'h0, 1'b1, 16'h7FFF, 8'h78, 1'b0);
    idle(5);
    chk("t5_no_wr", wr_seen - ws, 0);

    // Two lanes of one word both land; read back the merged word.
    push_wr(16'h8030, 8'h11);
    step(1'b0, 13'h0, 32'h0, 1'b1, 16'h8030, 8'h11, 1'b0);
    push_wr(16'hC030, 8'h33);
    step(1'b0, 13'h0, 32'h0, 1'b1, 16'hC030, 8'h33, 1'b0);
    idle(3);
    merged = finit(13'h30);
    merged[7:0]   = 8'h11;
    merged[23:16] = 8'h33;
    step(1'b1, 13'h30, merged, 1'b0, 16'h0, 8'h0, 1'b0);
    idle(5);

    // Reset with writes queued and reads in flight.
    step(1'b1, 13'h1C0, finit(13'h1C0), 1'b1, 16'h8070, 8'h55, 1'b0);
    step(1'b1, 13'h1C1, finit(13'h1C1), 1'b1, 16'h8071, 8'h66, 1'b0);
    #2;
    reset = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    ws = wr_seen; rs = rd_seen;
    nchk();
    chk_zero("t7_rst");
    @(posedge clk_ram); #1;
    reset = 1'b0;
    idle(8);
    chk("t7_no_wr", wr_seen - ws, 0);
    chk("t7_no_rd", rd_seen - rs, 0);
    chk("t7_full", cpu_full, 1'b0);

    chk("end_wr_queue", exp_wr.size(), 0);
    chk("end_rd_queue", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port 32-bit video RAM between CPU byte writes and video-fetch reads.
- The RAM holds four bit-planes per word; byte lane = plane.
- Video fetch has absolute priority and fixed latency.
- CPU writes are absorbed by a small FIFO and drained in cycles with no video fetch.
- Sits between the CPU bus / video timing logic and the RAM macro, replacing a dual-port RAM.

Parameters:
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, minimum 2.
- RAM_LAT, 1, RAM read latency in clocks from registered address to valid ram_rdata; legal values 1–3.

Ports:
- clk_ram  in  1  RAM clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_addr  in  16  CPU byte address; only addr[15]=1 targets VRAM.
- cpu_din  in  8  CPU write data.
- cpu_we  in  1  one-cycle write strobe, synchronous to clk_ram.
- cpu_full  out  1  FIFO holds FIFO_DEPTH entries.
- wr_overflow  out  1  sticky: a VRAM write was dropped.
- ovf_clr  in  1  clears wr_overflow.
- vid_req  in  1  one-cycle fetch request.
- vid_addr  in  13  word address {column[4:0], row[7:0]}.
- vid_q  out  32  fetched word.
- vid_valid  out  1  vid_q valid, one cycle.
- ram_addr  out  13  RAM word address.
- ram_we  out  1  RAM write enable.
- ram_be  out  4  byte enables.
- ram_wdata  out  32  write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; state IDLE; read-latency pipe cleared.
  - Reset mid-operation discards queued writes and in-flight reads; no vid_valid is produced for them.
- Write acceptance (cycle N, cpu_we=1):
  - If cpu_addr[15]=0: ignored.
  - If cpu_addr[15]=1 and FIFO not full: push {word=cpu_addr[12:0], lane=cpu_addr[14:13], data=cpu_din}.
  - If cpu_addr[15]=1 and FIFO full: the write is dropped and wr_overflow is set at N+1.
  - Fullness is evaluated on the occupancy at the start of cycle N. A pop in the same cycle does not make room.
- wr_overflow:
  - Clears on ovf_clr.
  - If ovf_clr and a drop occur in the same cycle, set wins.
- Issue state register, one RAM operation per cycle; the RAM outputs are registered:
  - READ: entered when vid_req=1 in cycle N. At N+1: ram_addr=vid_addr, ram_we=0, ram_be=0.
  - WRITE: entered when vid_req=0 and FIFO not empty in cycle N. The FIFO head pops in N. At N+1: ram_addr=word, ram_we=1, ram_be=one-hot(lane) (lane 0 → 4'b0001 … lane 3 → 4'b1000), ram_wdata={4{data}}.
  - IDLE: otherwise. ram_we=0, ram_be=0; ram_addr holds its last value.
  - A write entering the FIFO in cycle N is eligible to issue no earlier than N+1, so it appears on the RAM port at N+2 at the earliest.
- Read return:
  - A READ issued on the port at N+1 is tracked through a RAM_LAT-deep valid pipe.
  - vid_q is registered from ram_rdata.
  - vid_valid=1 at cycle N+2+RAM_LAT; total latency from vid_req is RAM_LAT+2 (3 for the default).
  - Back-to-back vid_req on consecutive cycles is supported; results return in order, one per cycle.
- Priority:
  - vid_req always wins; writes wait.
  - A continuous vid_req stream may starve writes indefinitely. Video timing guarantees idle slots (horizontal blanking); no starvation counter exists.
- Coherence:
  - No forwarding: a read to a word with a queued write returns the old RAM contents.
  - Writes reach RAM in FIFO order; two writes to different lanes of the same word are both applied.
- cpu_full is combinational from occupancy: 1 iff count == FIFO_DEPTH.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is width clog2(FIFO_DEPTH)+1 and never exceeds FIFO_DEPTH.

Test Plan:
- Reset, then cpu_we with addr=16'hA005, din=8'h3C, no vid_req → at the 2nd clock after the strobe: ram_we=1, ram_addr=13'h0005, ram_be=4'b0010, ram_wdata=32'h3C3C3C3C; cpu_full=0.
- vid_req with vid_addr=13'h1ABC, RAM model (RAM_LAT=1) returns 32'hDEADBEEF → ram_addr=13'h1ABC with ram_we=0 at +1; vid_valid=1 with vid_q=32'hDEADBEEF exactly 3 clocks after the request.
- Queue 3 writes, then hold vid_req for 10 consecutive cycles → zero ram_we during the burst; 10 in-order vid_valid pulses; the 3 writes issue on the 3 cycles following the burst, in order.
- Issue 5 VRAM writes back-to-back while vid_req is held high (FIFO_DEPTH=4) → cpu_full=1 after the 4th; the 5th is dropped and wr_overflow=1; ovf_clr clears it; only 4 writes later reach RAM.
- cpu_we with addr=16'h4000 → no FIFO push, no ram_we ever.
- Assert reset while 2 writes are queued and a read is in flight → no ram_we and no vid_valid after reset; all outputs 0; cpu_full=0.
